// File: rtl/reg_bank_wb.sv
// ---------------------------------------------------------------------------
// reg_bank_wb
//
// 32 x 32-bit register file for the write-back stage. It has two
// combinational read ports and one synchronous write port.
//   - r0 is hard-wired to zero. Writes to r0 are dropped and not counted.
//   - r29 ($sp) resets to SP_INIT. Every other register resets to zero.
//   - With BYPASS=1, a read that hits the register being written in this
//     cycle returns write_data before the clock edge. This forwarding is
//     suppressed while reset is high.
//   - wr_count is a free-running 16-bit debug count of accepted writes.
//     It wraps silently.
//
// Parameters
//   SP_INIT     reset value of r29
//   BYPASS      1 = same-cycle write-to-read forwarding enabled
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   reg_write   write enable for the current cycle
//   read_reg1   read port 1 address (rs)
//   read_reg2   read port 2 address (rt)
//   write_reg   destination address (rt, 29, 31 or rd)
//   write_data  write-back value
//   read_data1  value of register read_reg1
//   read_data2  value of register read_reg2
//   wr_count    number of accepted writes (debug)
// ---------------------------------------------------------------------------
module reg_bank_wb #(
    parameter logic [31:0] SP_INIT = 32'd227,
    parameter logic        BYPASS  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [15:0] wr_count
);

    localparam logic [4:0] SP_ADDR = 5'd29;

    logic [31:0] regs [32];
    logic        wr_accept;
    logic        fwd1;
    logic        fwd2;

    // reg_write is tested first. This keeps an X/Z on write_reg from
    // propagating into the enable while no write is requested.
    always_comb begin
        wr_accept = 1'b0;
        if (reg_write == 1'b1 && reset == 1'b0) begin
            wr_accept = (write_reg != 5'd0);
        end
    end

    // Storage. r0 has a slot so that indexing stays uniform, but that slot
    // is only ever cleared and is never presented on a read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (i == 29) begin
                    regs[i[4:0]] <= SP_INIT;
                end else begin
                    regs[i[4:0]] <= '0;
                end
            end
        end else if (wr_accept) begin
            regs[write_reg] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
        end else if (wr_accept) begin
            wr_count <= wr_count + 16'd1;
        end
    end

    // Forwarding hits. wr_accept already excludes reset and r0.
    always_comb begin
        fwd1 = 1'b0;
        fwd2 = 1'b0;
        if (BYPASS == 1'b1 && wr_accept) begin
            fwd1 = (read_reg1 == write_reg);
            fwd2 = (read_reg2 == write_reg);
        end
    end

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (read_reg1 != 5'd0) begin
            read_data1 = fwd1 ? write_data : regs[read_reg1];
        end
        if (read_reg2 != 5'd0) begin
            read_data2 = fwd2 ? write_data : regs[read_reg2];
        end
    end

    // SP_ADDR documents which slot the reset loop treats specially.
    logic unused_sp;
    assign unused_sp = ^SP_ADDR;

endmodule

// File: tb/tb_reg_bank_wb.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_wb
//
// Runs directed vectors against two copies of reg_bank_wb:
//   dut_bp  BYPASS = 1
//   dut_nb  BYPASS = 0
// Both copies share the same stimulus. The stimulus process pushes the
// hand-computed expected value of each output into a scoreboard queue.
// The monitor process pops the queue on every falling clock edge and
// compares each entry against the live DUT outputs.
// ---------------------------------------------------------------------------
module tb_reg_bank_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    logic [31:0] bp_rd1, bp_rd2, nb_rd1, nb_rd2;
    logic [15:0] bp_wc, nb_wc;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    reg_bank_wb #(.SP_INIT(32'd227), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .reset(reset), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data),
        .read_data1(bp_rd1), .read_data2(bp_rd2), .wr_count(bp_wc)
    );

    reg_bank_wb #(.SP_INIT(32'd227), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .reg_write(reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data),
        .read_data1(nb_rd1), .read_data2(nb_rd2), .wr_count(nb_wc)
    );

    // sel: 0/1/2 = rd1/rd2/wr_count of dut_bp, 3/4/5 = same for dut_nb
    typedef struct {
        int unsigned sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sbq[$];

    // port: 0 rd1, 1 rd2, 2 wr_count
    task automatic expect_out(input string name, input int unsigned port,
                              input logic [31:0] exp_bp, input logic [31:0] exp_nb);
        chk_t e;
        e.sel = port;     e.exp = exp_bp; e.name = {name, "/bp"}; sbq.push_back(e);
        e.sel = port + 3; e.exp = exp_nb; e.name = {name, "/nb"}; sbq.push_back(e);
    endtask

    // The monitor compares at the falling edge. The stimulus then waits for
    // the next rising edge and settles 1 time unit before it drives again.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
        reset      = rst;
        reg_write  = we;
        write_reg  = wa;
        write_data = wd;
        read_reg1  = ra1;
        read_reg2  = ra2;
    endtask

    // Monitor
    initial begin
        chk_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                case (e.sel)
                    0:       act = bp_rd1;
                    1:       act = bp_rd2;
                    2:       act = {16'd0, bp_wc};
                    3:       act = nb_rd1;
                    4:       act = nb_rd2;
                    default: act = {16'd0, nb_wc};
                endcase
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    // Stimulus
    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        @(posedge clk);
        #1;

        // Reset is still high, and a write to r29 is attempted. Forwarding
        // must be off, so the stored reset value shows.
        drive(1'b1, 1'b1, 5'd29, 32'h0000_0005, 5'd29, 5'd29);
        expect_out("rst_nobypass_rd1", 0, 32'd227, 32'd227);
        tick();

        // Reset state
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
        expect_out("reset_r29", 0, 32'd227, 32'd227);
        expect_out("reset_r5",  1, 32'd0,   32'd0);
        expect_out("reset_wc",  2, 32'd0,   32'd0);
        tick();

        // Write r31 (jal link) while reading r31 on both ports
        drive(1'b0, 1'b1, 5'd31, 32'h0000_0040, 5'd31, 5'd31);
        expect_out("r31_fwd_rd1", 0, 32'h40, 32'h0);
        expect_out("r31_fwd_rd2", 1, 32'h40, 32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
        expect_out("r31_rd1", 0, 32'h40, 32'h40);
        expect_out("r31_rd2", 1, 32'h40, 32'h40);
        expect_out("r31_wc",  2, 32'd1,  32'd1);
        tick();

        // Write to r0 is discarded and not counted
        drive(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd31);
        expect_out("r0_fwd", 0, 32'd0, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        expect_out("r0_rd1", 0, 32'd0, 32'd0);
        expect_out("r0_wc",  2, 32'd1, 32'd1);
        tick();

        // Same-cycle forwarding on port 1 only
        drive(1'b0, 1'b1, 5'd8, 32'h1234_5678, 5'd8, 5'd9);
        expect_out("r8_before_rd1", 0, 32'h1234_5678, 32'h0);
        expect_out("r8_before_rd2", 1, 32'h0,         32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
        expect_out("r8_after_rd1", 0, 32'h1234_5678, 32'h1234_5678);
        expect_out("r8_after_rd2", 1, 32'h1234_5678, 32'h1234_5678);
        expect_out("r8_after_wc",  2, 32'd2,         32'd2);
        tick();

        // Reset together with a write to r10: the write is lost and
        // all earlier writes are discarded
        drive(1'b1, 1'b1, 5'd10, 32'h0000_0005, 5'd8, 5'd10);
        expect_out("rst_wr_rd8",  0, 32'h1234_5678, 32'h1234_5678);
        expect_out("rst_wr_rd10", 1, 32'h0,         32'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd8);
        expect_out("post_rst_r10", 0, 32'd0, 32'd0);
        expect_out("post_rst_r8",  1, 32'd0, 32'd0);
        expect_out("post_rst_wc",  2, 32'd0, 32'd0);
        tick();

        // Unknown write address/data with reg_write low leaves state alone
        drive(1'b0, 1'b0, 5'bx, 32'bx, 5'd29, 5'd31);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd31);
        expect_out("x_idle_r29", 0, 32'd227, 32'd227);
        expect_out("x_idle_r31", 1, 32'd0,   32'd0);
        expect_out("x_idle_wc",  2, 32'd0,   32'd0);
        tick();

        // Back-to-back writes to r7, then a $sp update
        drive(1'b0, 1'b1, 5'd7, 32'h0000_0001, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd7, 32'h0000_0002, 5'd7, 5'd0);
        expect_out("r7_second_fwd", 0, 32'h2, 32'h1);
        tick();
        drive(1'b0, 1'b1, 5'd29, 32'h0000_0100, 5'd7, 5'd29);
        expect_out("r7_last",    0, 32'h2,   32'h2);
        expect_out("r29_fwd",    1, 32'h100, 32'd227);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd29);
        expect_out("r29_rd1", 0, 32'h100, 32'h100);
        expect_out("r29_rd2", 1, 32'h100, 32'h100);
        expect_out("r29_wc",  2, 32'd3,   32'd3);
        tick();

        // Counter wrap: reset, then 65536 writes to r3
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 65536; i++) begin
            drive(1'b0, 1'b1, 5'd3, 32'hA000_0000 | 32'(i), 5'd3, 5'd0);
            if (i == 65535) begin
                expect_out("wrap_wc_ffff", 2, 32'h0000_FFFF, 32'h0000_FFFF);
                tick();
            end else begin
                @(posedge clk);
                #1;
            end
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        expect_out("wrap_wc",  2, 32'd0,         32'd0);
        expect_out("wrap_r3",  0, 32'hA000_FFFF, 32'hA000_FFFF);
        expect_out("wrap_r3b", 1, 32'hA000_FFFF, 32'hA000_FFFF);
        tick();
        tick();

        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_bank_wb.md
REG_BANK_WB -- requirements
Module: reg_bank_wb

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-high reset.
- REQ-002: Parameter SP_INIT, default 32'd227, SHALL be the reset value of register 29 ($sp).
- REQ-003: Parameter BYPASS, default 1'b1, SHALL enable write-to-read forwarding within the same cycle when set to 1.
- REQ-004: Port clk, input, 1 bit, SHALL be the system clock; all state updates on its rising edge.
- REQ-005: Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
- REQ-006: Port reg_write, input, 1 bit, SHALL be the write enable for the current cycle.
- REQ-007: Port read_reg1, input, 5 bits, SHALL be the read port 1 address (instruction [25..21], rs).
- REQ-008: Port read_reg2, input, 5 bits, SHALL be the read port 2 address (instruction [20..16], rt).
- REQ-009: Port write_reg, input, 5 bits, SHALL be the destination address produced by the write-register select mux (rt, 29, 31 or rd).
- REQ-010: Port write_data, input, 32 bits, SHALL be the write-back value.
- REQ-011: Port read_data1, output, 32 bits, SHALL carry the register value at read_reg1.
- REQ-012: Port read_data2, output, 32 bits, SHALL carry the register value at read_reg2.
- REQ-013: Port wr_count, output, 16 bits, SHALL count accepted writes, for debug.

Function
- REQ-014: Storage SHALL be 32 x 32-bit registers, r0..r31.
- REQ-015: A write SHALL be accepted on a rising clk edge when reset=0, reg_write=1 and write_reg != 0; r[write_reg] <= write_data.
- REQ-016: r0 SHALL read 0 at all times; writes to address 0 are discarded and SHALL NOT increment wr_count.
- REQ-017: Reads SHALL be combinational, with zero-cycle latency from a read_regN change to read_dataN.
- REQ-018: With BYPASS=1, a read whose address equals write_reg (nonzero) while reg_write=1 and reset=0 SHALL return write_data in that same cycle.
- REQ-019: With BYPASS=0, the same read SHALL return the old stored value until the clock edge, then the new value.
- REQ-020: Both read ports SHALL operate independently; identical addresses on both ports SHALL return identical data.
- REQ-021: wr_count SHALL increment by 1 per accepted write and wrap from 16'hFFFF to 16'h0000 without any flag.
- REQ-022: A write of the same address on consecutive cycles SHALL leave the last written value stored.
- REQ-023: r31 writes (jal link) and r29 writes (stack pointer update) SHALL follow REQ-015 with no special handling.
- REQ-024: X or Z on write_reg or write_data while reg_write=0 SHALL NOT alter state.

Reset
- REQ-025: On a rising clk edge with reset=1, all registers SHALL clear to 0 except r29, which SHALL load SP_INIT.
- REQ-026: On a rising clk edge with reset=1, wr_count SHALL clear to 0.
- REQ-027: Reset SHALL take priority over a simultaneous write; the write is lost and not counted.
- REQ-028: While reset=1, bypass SHALL be disabled; read outputs SHALL show stored contents, which read as reset values after the first reset edge.
- REQ-029: Reset asserted between two writes SHALL discard all earlier writes; no partial state survives.

Verification
- REQ-030: Assert reset for 1 edge, then read ports 29 and 5 -> 227 and 0; wr_count=0.
- REQ-031: Write reg 31 = 0x0000_0040, then read both ports at 31 on the next cycle -> 0x40 on both; wr_count=1.
- REQ-032: Write reg 0 = 0xDEAD_BEEF -> read r0 = 0; wr_count unchanged.
- REQ-033: With BYPASS=1, write reg 8 = 0x1234_5678 while read_reg1=8 in the same cycle -> read_data1=0x1234_5678 before the edge; with BYPASS=0 -> old value before the edge and the new value after it.
- REQ-034: Write reg 10 = 5 with reset=1 on the same edge -> r10=0, wr_count=0.
- REQ-035: Perform 65536 writes to reg 3 -> wr_count=0 and r3 holds the last written value.
